// File: rtl/sar_search.sv
// sar_search: successive-approximation search driving a magnitude comparator
// Ports: clk, rst_n (async active-low); start launches a search;
//        gt/lt/eq are comparator flags for probe vs. hidden target;
//        probe is the trial value; busy is high while probing; done pulses one cycle;
//        result/steps/err report the outcome and are held until the next start.
module sar_search #(
   parameter int WIDTH = 8,
   localparam int SW = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             gt,
   input  logic             lt,
   input  logic             eq,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [SW-1:0]    steps,
   output logic             err
);
   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;
   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
   state_t           state;
   logic [WIDTH-1:0] acc, mask, nacc;
   logic [SW-1:0]    cnt;
   logic             onehot;
   // exactly one of the three flags set
   assign onehot = (gt ^ lt ^ eq) & ~(gt & lt & eq);
   // probe below target keeps the trial bit
   assign nacc = lt ? probe : acc;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         probe  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         steps  <= '0;
         err    <= 1'b0;
         acc    <= '0;
         mask   <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               acc    <= '0;
               mask   <= MSB;
               probe  <= MSB;
               cnt    <= SW'(1);
               result <= '0;
               steps  <= '0;
               err    <= 1'b0;
               busy   <= 1'b1;
               state  <= S_PROBE;
            end
            S_PROBE: if (!onehot) begin
               result <= '0;
               err    <= 1'b1;
               steps  <= cnt;
               busy   <= 1'b0;
               state  <= S_DONE;
            end else if (eq) begin
               result <= probe;
               steps  <= cnt;
               busy   <= 1'b0;
               state  <= S_DONE;
            end else begin
               acc <= nacc;
               if (mask[0]) begin
                  result <= nacc;
                  steps  <= SW'(WIDTH);
                  busy   <= 1'b0;
                  state  <= S_DONE;
               end else begin
                  mask  <= mask >> 1;
                  probe <= nacc | (mask >> 1);
                  cnt   <= cnt + SW'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               probe <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed self-checking bench for sar_search with a behavioural comparator
module tb_sar_search;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       gt, lt, eq;
   logic [7:0] probe, result;
   logic [3:0] steps;
   logic       busy, done, err;
   logic [7:0] target = 8'h00;
   logic       bad = 1'b0;
   int         tests = 0;
   int         fails = 0;
   logic [7:0] plist [0:15];
   int         pc;

   sar_search #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .gt(gt), .lt(lt), .eq(eq),
      .probe(probe), .busy(busy), .done(done), .result(result), .steps(steps), .err(err)
   );

   always #5 clk = ~clk;

   // comparator model; 'bad' forces an inconsistent gt=lt=1 reading
   assign gt = bad ? 1'b1 : (probe > target);
   assign lt = bad ? 1'b1 : (probe < target);
   assign eq = bad ? 1'b0 : (probe == target);

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // caller is at a negedge; returns at the negedge where done is seen (or timeout)
   task automatic search(input logic [7:0] t, input int bad_at, input bit mid_start,
                         input logic [7:0] xr, input logic [3:0] xs, input logic xe, input int xlat);
      int k;
      target = t;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      pc = 0;
      chk("busy_after_start", busy, 1);
      chk("first_probe", probe, 8'h80);
      chk("err_cleared", err, 0);
      plist[pc] = probe;
      pc++;
      bad = (bad_at == 1);
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
         if (busy && pc < 16) begin
            plist[pc] = probe;
            pc++;
         end
         bad = busy && (bad_at == k + 1);
         start = mid_start && (k == 3);
      end
      bad = 1'b0;
      start = 1'b0;
      chk("latency", k, xlat);
      chk("done", done, 1);
      chk("busy_low", busy, 0);
      chk("probe_zero", probe, 0);
      chk("result", result, xr);
      chk("steps", steps, xs);
      chk("err", err, xe);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_probe", probe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_steps", steps, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // eq on first probe
      search(8'h80, 0, 0, 8'h80, 4'd1, 1'b0, 2);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("result_held", result, 8'h80);
      chk("steps_held", steps, 4'd1);

      // 0x5A with a stray start pulse mid-search
      search(8'h5A, 0, 1, 8'h5A, 4'd7, 1'b0, 8);
      chk("p_count", pc, 7);
      chk("p1", plist[1], 8'h40);
      chk("p2", plist[2], 8'h60);
      chk("p3", plist[3], 8'h50);
      chk("p4", plist[4], 8'h58);
      chk("p5", plist[5], 8'h5C);
      chk("p6", plist[6], 8'h5A);
      @(negedge clk);
      chk("no_restart", busy, 0);
      @(negedge clk);

      // all gt
      search(8'h00, 0, 0, 8'h00, 4'd8, 1'b0, 9);
      chk("p7_zero", plist[7], 8'h01);
      @(negedge clk);

      // all lt, eq on eighth
      search(8'hFF, 0, 0, 8'hFF, 4'd8, 1'b0, 9);
      chk("p3_ff", plist[3], 8'hF0);
      chk("p7_ff", plist[7], 8'hFF);
      @(negedge clk);

      // inconsistent flags on third probe, then back-to-back search
      search(8'h5A, 3, 0, 8'h00, 4'd3, 1'b1, 4);
      search(8'h5A, 0, 0, 8'h5A, 4'd7, 1'b0, 8);
      @(negedge clk);

      // reset mid-search
      target = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_probe", probe, 0);
      chk("ar_busy", busy, 0);
      chk("ar_result", result, 0);
      chk("ar_steps", steps, 0);
      chk("ar_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | done | busy;
         end
         chk("no_done_after_reset", seen, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
